// File: rtl/dmem_write_buffer.sv
// Purpose : posted-write buffer between the core data port and a single-ported memory bus.
// Latency : a write accepted in cycle T appears on mem_write from T+2 (buffer idle); reads wait for the drain.
// Backpres: proc_stall while the buffer is full (write) or until the memory read completes (read).
//
// Ports:
//   clk, rst (async, active-low)
//   proc_read/proc_write/proc_addr/proc_wdata : core request, held until proc_stall is low
//   proc_stall/proc_rdata                     : core response (proc_rdata valid with read && !stall)
//   mem_read/mem_write/mem_addr/mem_wdata     : memory bus, decoded only from registered state
//   mem_rdata/mem_ready                       : memory response, single-cycle completion
//
// Optional: define WBUF_FWD_EN to answer reads that hit a buffered entry directly from the buffer.

module dmem_write_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 30,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          proc_read,
    input  logic          proc_write,
    input  logic [AW-1:0] proc_addr,
    input  logic [DW-1:0] proc_wdata,
    output logic          proc_stall,
    output logic [DW-1:0] proc_rdata,
    output logic          mem_read,
    output logic          mem_write,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, WRITE, GAP, READ} state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] addr_q [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [PW-1:0] head, tail;
    logic [CW-1:0] count;
    logic [AW-1:0] rd_addr;

    logic full, push, pop, latch_rd, read_done;

    // Full comes from the registered count only, so a pop this cycle frees
    // the slot for the next cycle, never for a same-cycle push.
    assign full      = (count == CW'(DEPTH));
    // A write presented together with a read is a protocol violation: the read wins.
    assign push      = proc_write && !proc_read && !full;
    assign pop       = (state == WRITE) && mem_ready;
    assign read_done = (state == READ) && mem_ready;

`ifdef WBUF_FWD_EN
    logic          fwd_hit;
    logic [DW-1:0] fwd_data;
    logic [PW-1:0] fwd_idx;

    // Walk entries oldest to youngest; the last match wins, which is the
    // youngest write to that address.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = head + PW'(i);
            if (proc_read && (CW'(i) < count) && (addr_q[fwd_idx] == proc_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[fwd_idx];
            end
        end
    end
`endif

    // Next-state logic. IDLE and GAP share the decision rule: buffered
    // writes always go first, which is what keeps reads behind writes.
    always_comb begin
        state_nxt = state;
        latch_rd  = 1'b0;
        case (state)
            IDLE, GAP: begin
                if (count != '0) begin
                    state_nxt = WRITE;
                end else if (proc_read) begin
                    state_nxt = READ;
                    latch_rd  = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            WRITE:   if (mem_ready) state_nxt = GAP;
            READ:    if (mem_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            rd_addr <= '0;
        end else begin
            state <= state_nxt;
            if (push) tail <= tail + PW'(1);
            if (pop)  head <= head + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (latch_rd) rd_addr <= proc_addr;
        end
    end

    // Entry storage needs no reset: validity is defined by head/count.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail] <= proc_addr;
            data_q[tail] <= proc_wdata;
        end
    end

    // Memory side: purely a decode of registered state, head entry and read address.
    assign mem_write = (state == WRITE);
    assign mem_read  = (state == READ);
    assign mem_addr  = (state == WRITE) ? addr_q[head] :
                       (state == READ)  ? rd_addr      : '0;
    assign mem_wdata = (state == WRITE) ? data_q[head] : '0;

    // Core side response.
    always_comb begin
        proc_stall = 1'b0;
        proc_rdata = '0;
        if (read_done) proc_rdata = mem_rdata;
`ifdef WBUF_FWD_EN
        if (fwd_hit) proc_rdata = fwd_data;
        if (proc_read)       proc_stall = !(read_done || fwd_hit);
        else if (proc_write) proc_stall = full;
`else
        if (proc_read)       proc_stall = !read_done;
        else if (proc_write) proc_stall = full;
`endif
        if (!rst) proc_stall = 1'b0;
    end

endmodule
